// File: rtl/add_pipe_pkg.sv
// -----------------------------------------------------------------------------
// add_pipe_pkg
// Shared types and constants for the add_pipe_acc pipelined adder/accumulator.
//   mode_e  : operation code carried on in_mode
//   LAT_MAX : deepest supported input-to-output latency
//   MODE_W  : width of the operation code
// -----------------------------------------------------------------------------
package add_pipe_pkg;

  localparam int LAT_MAX = 4;
  localparam int MODE_W  = 2;

  typedef enum logic [MODE_W-1:0] {
    ADD  = 2'd0,  // a + b
    SUB  = 2'd1,  // a - b
    ACC  = 2'd2,  // acc_q + a, accumulator updated
    LOAD = 2'd3   // acc_q <= a, result = a
  } mode_e;

endpackage

// File: rtl/add_sat_core.sv
// -----------------------------------------------------------------------------
// add_sat_core
// Combinational signed add/subtract with overflow detection and optional
// saturation. The sum is formed one bit wider than the operands so the true
// sign is always available for the overflow test.
// Ports:
//   op_a, op_b : signed operands (WIDTH)
//   op_sub     : 1 = op_a - op_b, 0 = op_a + op_b
//   op_pass    : 1 = forward op_a unchanged with no overflow (LOAD)
//   res_sum    : wrapped or clamped result (WIDTH)
//   res_ovf    : signed overflow flag for this result
// -----------------------------------------------------------------------------
module add_sat_core
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SAT   = 0
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  input  logic             op_pass,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_ovf
);

  logic [WIDTH:0] ext_a_s;
  logic [WIDTH:0] ext_b_s;
  logic [WIDTH:0] raw_s;
  logic           wrap_ovf_s;

  // Saturation bound selected by the sign of the wide result.
  function automatic logic [WIDTH-1:0] clamp_value(input logic neg);
    logic [WIDTH-1:0] val;
    if (neg) begin
      val = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      val = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return val;
  endfunction

  // Wide arithmetic, overflow detection and result selection.
  always_comb begin
    ext_a_s    = {op_a[WIDTH-1], op_a};
    ext_b_s    = {op_b[WIDTH-1], op_b};
    raw_s      = {(WIDTH+1){1'b0}};
    wrap_ovf_s = 1'b0;
    res_sum    = {WIDTH{1'b0}};
    res_ovf    = 1'b0;

    if (op_sub) begin
      raw_s = ext_a_s - ext_b_s;
    end else begin
      raw_s = ext_a_s + ext_b_s;
    end

    // The wide sign disagreeing with the narrow sign means the value
    // does not fit in WIDTH bits.
    wrap_ovf_s = raw_s[WIDTH] ^ raw_s[WIDTH-1];

    if (op_pass) begin
      res_sum = op_a;
      res_ovf = 1'b0;
    end else if (wrap_ovf_s && (SAT != 32'sd0)) begin
      res_sum = clamp_value(raw_s[WIDTH]);
      res_ovf = 1'b1;
    end else begin
      res_sum = raw_s[WIDTH-1:0];
      res_ovf = wrap_ovf_s;
    end
  end

endmodule

// File: rtl/add_pipe_acc.sv
// -----------------------------------------------------------------------------
// add_pipe_acc
// Pipelined signed adder / subtractor / accumulator with valid-ready
// handshakes on both sides. Arithmetic happens in stage 1; stages 2..LAT are a
// plain delay line. The whole pipeline advances together on one enable, so a
// full pipe with a stalled consumer freezes every stage.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake
//   in_a, in_b          : signed operands (WIDTH)
//   in_mode             : operation code (mode_e)
//   out_valid/out_ready : result handshake
//   out_sum, out_ovf    : result and its signed-overflow flag
//   acc_q               : current accumulator value
// -----------------------------------------------------------------------------
module add_pipe_acc
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 2,
  parameter int SAT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_ovf,
  output logic [WIDTH-1:0]  acc_q
);

  mode_e            mode_s;
  logic             adv_s;
  logic             in_fire_s;
  logic [WIDTH-1:0] core_a_s;
  logic [WIDTH-1:0] core_b_s;
  logic             core_sub_s;
  logic             core_pass_s;
  logic [WIDTH-1:0] core_sum_s;
  logic             core_ovf_s;
  logic [WIDTH-1:0] acc_r;

  logic             vld1_r;
  logic [WIDTH-1:0] sum1_r;
  logic             ovf1_r;

  // Per-stage views of the pipeline registers, index 1 = arithmetic stage.
  logic [LAT:1]             stg_vld_s;
  logic [LAT:1][WIDTH-1:0]  stg_sum_s;
  logic [LAT:1]             stg_ovf_s;

  assign mode_s    = mode_e'(in_mode);
  // Everything moves when the output slot is empty or being drained.
  assign adv_s     = !out_valid || out_ready;
  assign in_ready  = adv_s;
  assign in_fire_s = in_valid && adv_s;

  // Operand routing into the shared arithmetic core.
  always_comb begin
    core_a_s    = in_a;
    core_b_s    = in_b;
    core_sub_s  = 1'b0;
    core_pass_s = 1'b0;
    case (mode_s)
      ADD: begin
        core_sub_s = 1'b0;
      end
      SUB: begin
        core_sub_s = 1'b1;
      end
      ACC: begin
        core_a_s = acc_r;
        core_b_s = in_a;
      end
      LOAD: begin
        core_pass_s = 1'b1;
      end
      default: begin
        core_sub_s  = 1'b0;
        core_pass_s = 1'b0;
      end
    endcase
  end

  add_sat_core #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_core (
    .op_a    (core_a_s),
    .op_b    (core_b_s),
    .op_sub  (core_sub_s),
    .op_pass (core_pass_s),
    .res_sum (core_sum_s),
    .res_ovf (core_ovf_s)
  );

  // Accumulator: updated on the accepting edge so consecutive ACCs chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (in_fire_s && ((mode_s == ACC) || (mode_s == LOAD))) begin
      acc_r <= core_sum_s;
    end
  end

  // Stage 1: capture the arithmetic result; data only moves with a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_r <= 1'b0;
      sum1_r <= {WIDTH{1'b0}};
      ovf1_r <= 1'b0;
    end else if (adv_s) begin
      vld1_r <= in_fire_s;
      if (in_fire_s) begin
        sum1_r <= core_sum_s;
        ovf1_r <= core_ovf_s;
      end
    end
  end

  assign stg_vld_s[1] = vld1_r;
  assign stg_sum_s[1] = sum1_r;
  assign stg_ovf_s[1] = ovf1_r;

  // Stages 2..LAT: delay line. Bubbles pass as valid=0 but leave the data
  // registers untouched, so the last real result stays visible on out_sum.
  for (genvar g = 2; g <= LAT; g++) begin : g_stage
    logic             vld_r;
    logic [WIDTH-1:0] sum_r;
    logic             ovf_r;

    // Shift one stage forward on the shared enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r <= 1'b0;
        sum_r <= {WIDTH{1'b0}};
        ovf_r <= 1'b0;
      end else if (adv_s) begin
        vld_r <= stg_vld_s[g-1];
        if (stg_vld_s[g-1]) begin
          sum_r <= stg_sum_s[g-1];
          ovf_r <= stg_ovf_s[g-1];
        end
      end
    end

    assign stg_vld_s[g] = vld_r;
    assign stg_sum_s[g] = sum_r;
    assign stg_ovf_s[g] = ovf_r;
  end

  assign out_valid = stg_vld_s[LAT];
  assign out_sum   = stg_sum_s[LAT];
  assign out_ovf   = stg_ovf_s[LAT];
  assign acc_q     = acc_r;

endmodule

// File: tb/tb_add_pipe_acc.sv
// -----------------------------------------------------------------------------
// tb_add_pipe_acc
// Five add_pipe_acc instances (WIDTH=8) with different LAT/SAT settings share
// one stimulus stream. A transaction-level model tracks, per instance, the
// accumulator and an ordered list of in-flight results with the number of
// pipeline advances each has seen; a result is due at the output once it has
// seen LAT advances.
// -----------------------------------------------------------------------------
module tb_add_pipe_acc;

  localparam int W = 8;
  localparam int N = 5;

  int lat_m [N] = '{2, 2, 1, 3, 4};
  int sat_m [N] = '{0, 1, 0, 1, 0};

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic [W-1:0]        in_a;
  logic [W-1:0]        in_b;
  logic [1:0]          in_mode;
  logic                out_ready;
  logic [N-1:0]        in_ready_w;
  logic [N-1:0]        out_valid_w;
  logic [N-1:0]        out_ovf_w;
  logic [N-1:0][W-1:0] out_sum_w;
  logic [N-1:0][W-1:0] acc_q_w;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0]   data_q [N][$];
  int           age_q  [N][$];
  logic [W-1:0] acc_m  [N];
  logic [W-1:0] last_sum [N];
  logic         last_ovf [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    add_pipe_acc #(
      .WIDTH (W),
      .LAT   ((g == 2) ? 1 : (g == 3) ? 3 : (g == 4) ? 4 : 2),
      .SAT   (((g == 1) || (g == 3)) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .out_sum   (out_sum_w[g]),
      .out_ovf   (out_ovf_w[g]),
      .acc_q     (acc_q_w[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the mode definitions, on integers.
  function automatic logic [W:0] ref_op(input int sat, input logic [1:0] m,
                                        input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] acc);
    int sa, sb, sc, r, hi, lo;
    logic o;
    logic [W-1:0] s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sc = int'($signed(acc));
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    case (m)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = sc + sa;
      default: r = sa;
    endcase
    o = (m != 2'd3) && ((r > hi) || (r < lo));
    if (o && (sat != 0)) r = (r > 0) ? hi : lo;
    s = r[W-1:0];
    return {o, s};
  endfunction

  function automatic bit head_due(input int k);
    return (age_q[k].size() > 0) && (age_q[k][0] == lat_m[k]);
  endfunction

  // Model of one clock edge for instance k, using the inputs now applied.
  task automatic model_edge(input int k);
    bit ev;
    logic [W:0] res;
    ev = head_due(k);
    if (!ev || out_ready) begin
      if (ev) begin
        void'(data_q[k].pop_front());
        void'(age_q[k].pop_front());
      end
      for (int i = 0; i < age_q[k].size(); i++) age_q[k][i] = age_q[k][i] + 1;
      if (in_valid) begin
        res = ref_op(sat_m[k], in_mode, in_a, in_b, acc_m[k]);
        data_q[k].push_back(res);
        age_q[k].push_back(1);
        if ((in_mode == 2'd2) || (in_mode == 2'd3)) acc_m[k] = res[W-1:0];
      end
    end
  endtask

  task automatic check_state(input int k);
    bit ev;
    ev = head_due(k);
    chk($sformatf("dut%0d out_valid", k), 64'(out_valid_w[k]), 64'(ev));
    if (ev) begin
      last_sum[k] = data_q[k][0][W-1:0];
      last_ovf[k] = data_q[k][0][W];
    end
    chk($sformatf("dut%0d out_sum", k), 64'(out_sum_w[k]), 64'(last_sum[k]));
    chk($sformatf("dut%0d out_ovf", k), 64'(out_ovf_w[k]), 64'(last_ovf[k]));
    chk($sformatf("dut%0d acc_q", k), 64'(acc_q_w[k]), 64'(acc_m[k]));
  endtask

  // One cycle: apply inputs at the falling edge, check readiness, advance the
  // model, then check outputs at the next falling edge.
  task automatic step(input bit v, input logic [1:0] m, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit r);
    in_valid  = v;
    in_mode   = m;
    in_a      = a;
    in_b      = b;
    out_ready = r;
    #1;
    for (int k = 0; k < N; k++)
      chk($sformatf("dut%0d in_ready", k), 64'(in_ready_w[k]), 64'(!head_due(k) || r));
    for (int k = 0; k < N; k++) model_edge(k);
    @(negedge clk);
    for (int k = 0; k < N; k++) check_state(k);
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("dut%0d rst out_valid", k), 64'(out_valid_w[k]), 64'd0);
      chk($sformatf("dut%0d rst acc_q", k), 64'(acc_q_w[k]), 64'd0);
      chk($sformatf("dut%0d rst out_sum", k), 64'(out_sum_w[k]), 64'd0);
      chk($sformatf("dut%0d rst in_ready", k), 64'(in_ready_w[k]), 64'd1);
      data_q[k].delete();
      age_q[k].delete();
      acc_m[k]    = '0;
      last_sum[k] = '0;
      last_ovf[k] = 1'b0;
    end
    in_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) check_state(k);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 8'h7F;
      1:       v = 8'h80;
      2:       v = 8'hFF;
      3:       v = 8'h00;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 2'd0;
    out_ready = 1'b1;
    do_reset(2);

    // Directed: wrap/saturate on ADD and SUB, then LOAD/ACC chaining.
    step(1'b1, 2'd0, 8'd5,   8'd10, 1'b1);
    step(1'b1, 2'd0, 8'd100, 8'd55, 1'b1);
    chk("dir add15 sum", 64'(out_sum_w[0]), 64'd15);
    chk("dir add15 ovf", 64'(out_ovf_w[0]), 64'd0);
    step(1'b1, 2'd1, 8'h9C,  8'd50, 1'b1);
    chk("dir wrap sum",  64'(out_sum_w[0]), 64'h9B);
    chk("dir wrap ovf",  64'(out_ovf_w[0]), 64'd1);
    chk("dir sat+ sum",  64'(out_sum_w[1]), 64'h7F);
    chk("dir sat+ ovf",  64'(out_ovf_w[1]), 64'd1);
    step(1'b1, 2'd3, 8'd105, 8'd0,  1'b1);
    chk("dir sat- sum",  64'(out_sum_w[1]), 64'h80);
    chk("dir sat- ovf",  64'(out_ovf_w[1]), 64'd1);
    step(1'b1, 2'd2, 8'd10,  8'd0,  1'b1);
    step(1'b1, 2'd2, 8'd45,  8'd0,  1'b1);
    chk("dir acc wrap",  64'(acc_q_w[0]), 64'hA0);
    chk("dir acc sat",   64'(acc_q_w[1]), 64'h7F);
    repeat (6) step(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);

    // Stall: stream inputs while the consumer is blocked for five cycles.
    repeat (3) step(1'b1, 2'd0, rnd_operand(), rnd_operand(), 1'b1);
    repeat (5) step(1'b1, 2'(2'($urandom)), rnd_operand(), rnd_operand(), 1'b0);
    repeat (8) step(1'b1, 2'(2'($urandom)), rnd_operand(), rnd_operand(), 1'b1);

    // Reset with transactions in flight.
    step(1'b1, 2'd3, 8'd42, 8'd0, 1'b1);
    step(1'b1, 2'd2, 8'd7,  8'd0, 1'b1);
    do_reset(2);
    repeat (6) step(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);

    // Random traffic with back-pressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ((c % 900) == 899) begin
        do_reset(1);
      end else begin
        step($urandom_range(0, 3) != 0, 2'($urandom), rnd_operand(), rnd_operand(),
             $urandom_range(0, 9) < 7);
      end
    end
    repeat (8) step(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
